// File: rtl/alu_arb_if.sv
// Bundle of every request, ALU and response signal around the ALU arbiter.
//   req0_*  : execute-stage requester (may update flags via req0_setflags)
//   req1_*  : address-generator requester (never updates flags)
//   alu_*   : registered operands to the shared combinational ALU, and its result/flags
//   resp_*  : registered result, one-cycle valid pulse, requester id
//   apsr_*  : registered condition flags
// Modport slave is the arbiter; modport master is the environment (requesters + ALU).
interface alu_arb_if;
    logic        req0_valid;
    logic        req0_cin;
    logic        req0_setflags;
    logic [31:0] req0_src1;
    logic [31:0] req0_src2;
    logic [4:0]  req0_op;
    logic        req0_ready;

    logic        req1_valid;
    logic        req1_cin;
    logic [31:0] req1_src1;
    logic [31:0] req1_src2;
    logic [4:0]  req1_op;
    logic        req1_ready;

    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic        alu_cin;
    logic [4:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_n;
    logic        alu_z;
    logic        alu_c;
    logic        alu_v;

    logic        resp_valid;
    logic        resp_id;
    logic [31:0] resp_data;

    logic        apsr_n;
    logic        apsr_z;
    logic        apsr_c;
    logic        apsr_v;

    modport slave (
        input  req0_valid, req0_cin, req0_setflags, req0_src1, req0_src2, req0_op,
        output req0_ready,
        input  req1_valid, req1_cin, req1_src1, req1_src2, req1_op,
        output req1_ready,
        output alu_src1, alu_src2, alu_cin, alu_op,
        input  alu_result, alu_n, alu_z, alu_c, alu_v,
        output resp_valid, resp_id, resp_data,
        output apsr_n, apsr_z, apsr_c, apsr_v
    );

    modport master (
        output req0_valid, req0_cin, req0_setflags, req0_src1, req0_src2, req0_op,
        input  req0_ready,
        output req1_valid, req1_cin, req1_src1, req1_src2, req1_op,
        input  req1_ready,
        input  alu_src1, alu_src2, alu_cin, alu_op,
        output alu_result, alu_n, alu_z, alu_c, alu_v,
        input  resp_valid, resp_id, resp_data,
        input  apsr_n, apsr_z, apsr_c, apsr_v
    );
endinterface

// File: rtl/alu_arb.sv
// Two-requester arbiter in front of one shared combinational ALU.
// Requester 0 has priority, but requester 1 is forced through after
// STARVE_MAX consecutive req0 grants while it waits. Non-MUL ops complete one
// per cycle; MUL occupies the ALU for two cycles and stalls both requesters.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : alu_arb_if.slave (requests, ALU operands/results, response, flags)
module alu_arb #(
    parameter int STARVE_MAX = 4
) (
    input  logic      clk,
    input  logic      rst,
    alu_arb_if.slave  bus
);
    localparam logic [4:0] OP_MUL  = 5'd8;
    localparam logic [4:0] OP_SRC1 = 5'd9;
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, EXEC, MULW} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;

    logic [31:0] alu_src1_q, alu_src2_q;
    logic        alu_cin_q;
    logic [4:0]  alu_op_q;
    logic        setflags_q;
    logic        id_q;

    logic        resp_valid_q, resp_id_q;
    logic [31:0] resp_data_q;
    logic [3:0]  apsr_q;

    logic grant0, grant1, stall, acc0, acc1, accept, capture;

    // req1 wins only when req0 is absent or req1 has waited STARVE_MAX grants.
    assign grant1 = bus.req1_valid && (!bus.req0_valid || starve_q == CNT_MAX);
    assign grant0 = !grant1 && bus.req0_valid;

    // A MUL holds the ALU for its EXEC cycle and the following MULW cycle.
    assign stall  = (state_q == EXEC && alu_op_q == OP_MUL) || state_q == MULW;

    assign bus.req0_ready = grant0 && !stall && !rst;
    assign bus.req1_ready = grant1 && !stall && !rst;

    assign acc0    = bus.req0_valid && bus.req0_ready;
    assign acc1    = bus.req1_valid && bus.req1_ready;
    assign accept  = acc0 || acc1;
    assign capture = (state_q == EXEC && alu_op_q != OP_MUL) || state_q == MULW;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? EXEC : IDLE;
            EXEC:    state_d = (alu_op_q == OP_MUL) ? MULW : (accept ? EXEC : IDLE);
            MULW:    state_d = accept ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counter tracks how many req0 grants in a row happened while req1 waited.
    always_comb begin
        starve_d = starve_q;
        if (!bus.req1_valid || acc1)
            starve_d = '0;
        else if (acc0 && starve_q != CNT_MAX)
            starve_d = starve_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_q     <= '0;
            alu_src1_q   <= '0;
            alu_src2_q   <= '0;
            alu_cin_q    <= 1'b0;
            alu_op_q     <= OP_SRC1;
            setflags_q   <= 1'b0;
            id_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= '0;
            apsr_q       <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            resp_valid_q <= capture;
            // Result of the held op is taken before the operand registers are
            // overwritten by a request accepted on the same edge.
            if (capture) begin
                resp_data_q <= bus.alu_result;
                resp_id_q   <= id_q;
                if (!id_q && setflags_q)
                    apsr_q <= {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
            end
            if (accept) begin
                alu_src1_q <= acc1 ? bus.req1_src1 : bus.req0_src1;
                alu_src2_q <= acc1 ? bus.req1_src2 : bus.req0_src2;
                alu_cin_q  <= acc1 ? bus.req1_cin  : bus.req0_cin;
                alu_op_q   <= acc1 ? bus.req1_op   : bus.req0_op;
                setflags_q <= acc0 && bus.req0_setflags;
                id_q       <= acc1;
            end
        end
    end

    assign bus.alu_src1   = alu_src1_q;
    assign bus.alu_src2   = alu_src2_q;
    assign bus.alu_cin    = alu_cin_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.apsr_n     = apsr_q[3];
    assign bus.apsr_z     = apsr_q[2];
    assign bus.apsr_c     = apsr_q[1];
    assign bus.apsr_v     = apsr_q[0];
endmodule
